ula_pilha_exec: RTL and testbench

Execution sequencer that sits between the control unit and the operand stack, on the stack's consumer side. On a start pulse it pops one or two operands from the stack, computes an 8-bit ALU result, and pushes the result back through the stack's ALU data input. The stack's push/pop select is driven from this block's stk_push and stk_pop outputs. This block is the producer of the stack's ALU data input.

---
 rtl/ula_pilha_exec_pkg.sv | 34 +++
 rtl/ula_pilha_exec_if.sv | 24 ++
 rtl/ula_core.sv | 51 +++++
 rtl/ula_pilha_exec.sv | 104 ++++++++++
 tb/tb_ula_pilha_exec.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ula_pilha_exec_pkg.sv
// Shared definitions for the stack-side ALU sequencer: opcodes, FSM encoding
// and the unary/binary operand-count helper.
package pilha_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int TOS_W_DEF = 16;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_POP1 = 3'd1,
    ST_POP2 = 3'd2,
    ST_CAPA = 3'd3,
    ST_EXEC = 3'd4,
    ST_PUSH = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

  // NOT, SHL and SHR consume a single operand; all others take two.
  function automatic logic is_unary(input logic [2:0] op);
    return (op == OP_NOT) || (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/ula_pilha_exec_if.sv
// Consumer-side connection between the ALU sequencer (master) and the operand stack (slave).
interface ula_pilha_exec_if #(
  parameter int WIDTH = pilha_pkg::WIDTH_DEF,
  parameter int TOS_W = pilha_pkg::TOS_W_DEF
) ();
  // Protocol: stk_pop and stk_push are single-cycle commands, never high together.
  // A pop in cycle n presents its word on stk_dout in cycle n+1; a push writes
  // din_ula in the cycle stk_push is high. stk_tos is the live entry count.
  logic [TOS_W-1:0] stk_tos;
  logic [WIDTH-1:0] stk_dout;
  logic             stk_pop;
  logic             stk_push;
  logic [WIDTH-1:0] din_ula;

  modport master (
    input  stk_tos, stk_dout,
    output stk_pop, stk_push, din_ula
  );

  modport slave (
    output stk_tos, stk_dout,
    input  stk_pop, stk_push, din_ula
  );
endinterface

// File: rtl/ula_core.sv
// Combinational ALU: result = a op b, carry is carry-out, borrow or shifted-out bit.
module ula_core
  import pilha_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] wide;

  always_comb begin
    wide   = '0;
    result = '0;
    carry  = 1'b0;
    case (opcode)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[WIDTH-1:0];
        carry  = wide[WIDTH];
      end
      OP_SUB: begin
        // The extra top bit of the extended difference is the borrow (a < b).
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[WIDTH-1:0];
        carry  = wide[WIDTH];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[WIDTH-2:0], 1'b0};
        carry  = a[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, a[WIDTH-1:1]};
        carry  = a[0];
      end
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ula_pilha_exec.sv
// Execution sequencer: pops one or two operands from the stack, runs the ALU
// and pushes the result back; underflow is reported with a single err/done pulse.
module ula_pilha_exec
  import pilha_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int TOS_W = TOS_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2:0]             opcode,
  ula_pilha_exec_if.master       stk,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   flag_z,
  output logic                   flag_c,
  output state_t                 state_dbg
);

  state_t           state, state_nxt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             underflow;

  ula_core #(.WIDTH(WIDTH)) u_core (
    .a      (a_q),
    .b      (b_q),
    .opcode (op_q),
    .result (alu_res),
    .carry  (alu_c)
  );

  assign underflow = is_unary(opcode) ? (stk.stk_tos < TOS_W'(1))
                                      : (stk.stk_tos < TOS_W'(2));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = underflow ? ST_ERR : ST_POP1;
      ST_POP1: state_nxt = is_unary(op_q) ? ST_CAPA : ST_POP2;
      ST_POP2: state_nxt = ST_CAPA;
      ST_CAPA: state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_PUSH;
      ST_PUSH: state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    stk.stk_pop  = 1'b0;
    stk.stk_push = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    busy         = (state != ST_IDLE);
    case (state)
      ST_POP1, ST_POP2: stk.stk_pop = 1'b1;
      ST_PUSH: begin
        stk.stk_push = 1'b1;
        done         = 1'b1;
      end
      ST_ERR: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand capture follows the stack's one-cycle read latency: the first pop's
  // word (B) lands during POP2, the second (or only) during CAPA.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) op_q <= opcode;
      if (state == ST_POP2)          b_q  <= stk.stk_dout;
      if (state == ST_CAPA)          a_q  <= stk.stk_dout;
      if (state == ST_EXEC) begin
        result_q <= alu_res;
        flag_z   <= (alu_res == '0);
        flag_c   <= alu_c;
      end
    end
  end

  assign stk.din_ula = result_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_ula_pilha_exec.sv
// Bench for ula_pilha_exec: behavioural stack plus reference ALU, scoreboard
// queue filled by the driver and drained by a done-triggered monitor.
module tb_ula_pilha_exec;
  import pilha_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       busy, done, err, flag_z, flag_c;
  state_t     state_dbg;

  ula_pilha_exec_if stk_if ();

  ula_pilha_exec dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .opcode    (opcode),
    .stk       (stk_if),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural stack ----------------
  logic [7:0]  mem [0:255];
  logic [15:0] tos_r = 16'd0;
  logic [7:0]  dout_r = 8'd0;
  assign stk_if.stk_tos  = tos_r;
  assign stk_if.stk_dout = dout_r;

  always @(posedge clk) begin
    if (stk_if.stk_pop && tos_r != 16'd0) begin
      dout_r <= mem[8'(tos_r - 16'd1)];
      tos_r  <= tos_r - 16'd1;
    end else if (stk_if.stk_push) begin
      mem[tos_r[7:0]] <= stk_if.din_ula;
      tos_r           <= tos_r + 16'd1;
    end
  end

  // ---------------- reference model state ----------------
  int   mstk[$];
  logic mz = 1'b0, mc = 1'b0;
  int   n_tests = 0, n_fail = 0;
  int   push_cnt = 0;
  int   c0 = 0;
  int   pop_q[$];
  // {done_cycle[15:0], err, z, c, result[7:0]}
  logic [26:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [9:0] ref_alu(input int op, input int a, input int b);
    int r, c;
    r = 0; c = 0;
    case (op)
      0: begin r = a + b; c = (r > 255) ? 1 : 0; r = r % 256; end
      1: begin c = (a < b) ? 1 : 0; r = (a - b + 256) % 256; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - a;
      6: begin r = (a * 2) % 256; c = a / 128; end
      default: begin r = a / 2; c = a % 2; end
    endcase
    return {(r == 0), c[0], r[7:0]};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [26:0] e;
    if (stk_if.stk_pop) pop_q.push_back(cyc);
    if (!rst) begin
      if (stk_if.stk_push) push_cnt++;
      if (stk_if.stk_pop && stk_if.stk_push) check("pop_push_overlap", 32'd1, 32'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", 32'(cyc[15:0]), 32'(e[26:11]));
          check("err", 32'(err), 32'(e[10]));
          if (e[10]) begin
            check("err_push", 32'(stk_if.stk_push), 32'd0);
            check("err_pop", 32'(stk_if.stk_pop), 32'd0);
          end else begin
            check("push", 32'(stk_if.stk_push), 32'd1);
            check("din_ula", 32'(stk_if.din_ula), 32'(e[7:0]));
          end
          check("flag_z", 32'(flag_z), 32'(e[9]));
          check("flag_c", 32'(flag_c), 32'(e[8]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_stack();
    @(negedge clk);
    tos_r = 16'd0;
    mstk.delete();
  endtask

  task automatic push_val(input int v);
    mem[tos_r[7:0]] = 8'(v);
    tos_r = tos_r + 16'd1;
    mstk.push_back(v & 255);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
    check("tos", 32'(tos_r), 32'(mstk.size()));
  endtask

  task automatic issue(input logic [2:0] op, input bit retrig);
    int need, a, b;
    logic [9:0] r;
    @(negedge clk);
    need = (op >= 3'd5) ? 1 : 2;
    c0 = cyc;
    if (mstk.size() < need) begin
      exp_q.push_back({16'(cyc + 1), 1'b1, mz, mc, 8'h00});
    end else begin
      b = 0;
      if (need == 2) b = mstk.pop_back();
      a = mstk.pop_back();
      r = ref_alu(int'(op), a, b);
      mstk.push_back(int'(r[7:0]));
      mz = r[9];
      mc = r[8];
      exp_q.push_back({16'(cyc + need + 3), 1'b0, r[9], r[8], r[7:0]});
    end
    start = 1'b1;
    opcode = op;
    @(negedge clk);
    start = 1'b0;
    if (retrig) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pc;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pop_push", 32'({stk_if.stk_pop, stk_if.stk_push, err}), 32'd0);
    check("rst_din_flags", 32'({stk_if.din_ula, flag_z, flag_c}), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst = 1'b0;

    // ADD [5,3] with pop timing
    clear_stack(); push_val(5); push_val(3);
    pop_q.delete();
    issue(3'(OP_ADD), 1'b0);
    check("add_pop_count", 32'(pop_q.size()), 32'd2);
    check("add_pop1_cycle", 32'(pop_q[0]), 32'(c0 + 1));
    check("add_pop2_cycle", 32'(pop_q[1]), 32'(c0 + 2));

    clear_stack(); push_val(5); push_val(3); issue(3'(OP_SUB), 1'b0);
    clear_stack(); push_val(3); push_val(5); issue(3'(OP_SUB), 1'b0);
    clear_stack(); push_val(7); push_val(7); issue(3'(OP_SUB), 1'b0);

    // underflow: only one entry for a binary op
    clear_stack(); push_val(9);
    pop_q.delete();
    issue(3'(OP_ADD), 1'b0);
    check("err_no_pops", 32'(pop_q.size()), 32'd0);

    clear_stack(); push_val(8'h81); issue(3'(OP_SHL), 1'b0);
    clear_stack(); push_val(8'hFF); issue(3'(OP_NOT), 1'b0);
    clear_stack(); issue(3'(OP_SHR), 1'b0);

    // start re-pulsed while busy must be dropped
    clear_stack(); push_val(20); push_val(30);
    pc = push_cnt;
    issue(3'(OP_ADD), 1'b1);
    repeat (4) @(negedge clk);
    check("retrig_push_count", 32'(push_cnt - pc), 32'd1);

    // reset during CAPA of an ADD
    clear_stack(); push_val(5); push_val(3);
    pc = push_cnt;
    @(negedge clk);
    c0 = cyc;
    start = 1'b1; opcode = 3'(OP_ADD);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("midrst_outputs", 32'({busy, done, err, stk_if.stk_pop, stk_if.stk_push}), 32'd0);
    check("midrst_din_flags", 32'({stk_if.din_ula, flag_z, flag_c}), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst = 1'b0;
    mstk.delete(); mz = 1'b0; mc = 1'b0;
    repeat (8) @(negedge clk);
    check("midrst_no_push", 32'(push_cnt - pc), 32'd0);
    check("midrst_tos", 32'(tos_r), 32'd0);
    push_val(100); push_val(200);
    issue(3'(OP_ADD), 1'b0);

    // randomized operations
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0 || tos_r > 16'd100) clear_stack();
      else @(negedge clk);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) push_val(int'($urandom_range(0, 255)));
      issue(3'($urandom_range(0, 7)), 1'b0);
    end

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
